// File: rtl/silife_uart_cmd.sv
// UART command processor for the SiLife grid core: decodes single-byte commands,
// drives step/write/reset controls and streams an ASCII dump of the grid.
module silife_uart_cmd #(
  parameter int ROWS   = 32,
  parameter int COLS   = 8,
  parameter int CNT_W  = 16,
  parameter int RD_LAT = 1,
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [ROW_W-1:0] grid_row_sel,
  output logic             grid_wr_en,
  output logic [COLS-1:0]  grid_wr_data,
  input  logic [COLS-1:0]  grid_rd_data,
  output logic             grid_en,
  output logic             grid_rst_n,
  output logic             max_en
);

  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int WAIT_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
  localparam logic [7:0] CR = 8'h0d, LF = 8'h0a;

  typedef enum logic [2:0] {
    IDLE, RESP, RESP_LF, RUN, DUMP_WAIT, DUMP_CHAR, DUMP_CR, DUMP_LF
  } state_t;

  state_t            state, state_d;
  logic [7:0]        tx_data_d;
  logic              tx_valid_d;
  logic [CNT_W-1:0]  step_count, step_count_d, run_left, run_left_d;
  logic              run_en, run_en_d;
  logic [ROW_W-1:0]  wr_row, wr_row_d, dump_row, dump_row_d;
  logic [COL_W-1:0]  wr_col, wr_col_d, dump_col, dump_col_d;
  logic [COLS-1:0]   wr_data, wr_data_d, line_buf, line_buf_d;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_d;
  logic              hdr, hdr_d;
  logic              step_pulse, step_pulse_d, wr_pulse, wr_pulse_d;
  logic              demo_pulse, demo_pulse_d, rst_pulse, rst_pulse_d;

  logic              accept, dumping;
  logic [7:0]        lc;
  logic [CNT_W+3:0]  cnt_ext, cnt_mac;
  logic [CNT_W-1:0]  cnt_sat;
  logic [COL_W-1:0]  col_nxt;

  function automatic logic [7:0] cell_char(input logic b);
    return b ? 8'h23 : 8'h2e;
  endfunction

  assign accept   = rx_valid & rx_ready;
  assign dumping  = (state == RESP_LF) || (state == DUMP_WAIT) || (state == DUMP_CHAR) ||
                    (state == DUMP_CR) || (state == DUMP_LF);
  assign lc       = (rx_data >= 8'h41 && rx_data <= 8'h5a) ? (rx_data | 8'h20) : rx_data;
  assign col_nxt  = dump_col + 1'b1;

  // step_count*10 + digit computed 4 bits wider so overflow is visible before saturation
  assign cnt_ext  = {4'b0, step_count};
  assign cnt_mac  = (cnt_ext << 3) + (cnt_ext << 1) + {{CNT_W{1'b0}}, rx_data[3:0]};
  assign cnt_sat  = (cnt_mac > {4'b0, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : cnt_mac[CNT_W-1:0];

  assign rx_ready     = (state == IDLE) & ~rst;
  assign grid_en      = step_pulse | (state == RUN) | (run_en & ~dumping);
  assign grid_row_sel = dumping ? dump_row : wr_row;
  assign grid_wr_en   = wr_pulse | demo_pulse;
  assign grid_wr_data = wr_data;
  assign grid_rst_n   = ~(rst | rst_pulse);
  assign max_en       = ~dumping;

  always_comb begin
    state_d      = state;
    tx_data_d    = tx_data;
    tx_valid_d   = tx_valid;
    step_count_d = step_count;
    run_left_d   = run_left;
    run_en_d     = run_en;
    wr_col_d     = wr_col;
    wr_data_d    = wr_data;
    dump_row_d   = dump_row;
    dump_col_d   = dump_col;
    line_buf_d   = line_buf;
    wait_cnt_d   = wait_cnt;
    hdr_d        = hdr;
    step_pulse_d = 1'b0;
    wr_pulse_d   = 1'b0;
    demo_pulse_d = 1'b0;
    rst_pulse_d  = 1'b0;
    // a row write commits the row pointer one cycle after its strobe
    wr_row_d     = wr_pulse ? ((wr_row == ROW_LAST) ? '0 : wr_row + 1'b1) : wr_row;

    unique case (state)
      IDLE: if (accept) begin
        state_d    = RESP;
        tx_valid_d = 1'b1;
        tx_data_d  = rx_data;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
          step_count_d = cnt_sat;
        end else if (rx_data == 8'h2e || rx_data == 8'h23) begin
          wr_data_d[wr_col] = (rx_data == 8'h23);
          if (wr_col == COL_LAST) begin
            wr_col_d   = '0;
            wr_pulse_d = 1'b1;
          end else begin
            wr_col_d = wr_col + 1'b1;
          end
        end else begin
          case (lc)
            8'h73: begin step_pulse_d = 1'b1; tx_data_d = 8'h53; end
            8'h6e: begin
              tx_data_d = 8'h4e;
              if (step_count != '0) begin
                tx_valid_d = 1'b0;
                run_left_d = step_count;
                state_d    = RUN;
              end
            end
            8'h72: begin
              step_pulse_d = (rx_data == 8'h52);
              tx_data_d    = CR;
              hdr_d        = 1'b1;
              dump_row_d   = '0;
              state_d      = DUMP_CR;
            end
            8'h77: begin wr_row_d = '0; wr_col_d = '0; tx_data_d = 8'h57; end
            8'h64: begin
              rst_pulse_d  = 1'b1;
              demo_pulse_d = 1'b1;
              run_en_d     = 1'b1;
              tx_data_d    = 8'h44;
            end
            8'h70: begin run_en_d = ~run_en; tx_data_d = 8'h50; end
            8'h7a: begin
              rst_pulse_d  = 1'b1;
              run_en_d     = 1'b0;
              step_count_d = '0;
              tx_data_d    = 8'h5a;
            end
            default: tx_data_d = 8'h58;
          endcase
        end
      end
      RESP: if (tx_ready) begin
        tx_valid_d = 1'b0;
        state_d    = IDLE;
      end
      RUN: begin
        if (run_left == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          state_d      = RESP;
          tx_valid_d   = 1'b1;
          step_count_d = '0;
        end else begin
          run_left_d = run_left - 1'b1;
        end
      end
      DUMP_CR: if (tx_ready) begin
        tx_data_d = LF;
        state_d   = hdr ? RESP_LF : DUMP_LF;
      end
      // header LF: after it the first row read starts
      RESP_LF: if (tx_ready) begin
        tx_valid_d = 1'b0;
        hdr_d      = 1'b0;
        wait_cnt_d = '0;
        state_d    = DUMP_WAIT;
      end
      DUMP_LF: if (tx_ready) begin
        tx_valid_d = 1'b0;
        if (dump_row == ROW_LAST) begin
          state_d = IDLE;
        end else begin
          dump_row_d = dump_row + 1'b1;
          wait_cnt_d = '0;
          state_d    = DUMP_WAIT;
        end
      end
      DUMP_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          line_buf_d = grid_rd_data;
          dump_col_d = '0;
          tx_valid_d = 1'b1;
          tx_data_d  = cell_char(grid_rd_data[0]);
          state_d    = DUMP_CHAR;
        end else begin
          wait_cnt_d = wait_cnt + 1'b1;
        end
      end
      DUMP_CHAR: if (tx_ready) begin
        if (dump_col == COL_LAST) begin
          tx_data_d = CR;
          state_d   = DUMP_CR;
        end else begin
          dump_col_d = col_nxt;
          tx_data_d  = cell_char(line_buf[col_nxt]);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      step_count <= '0;
      run_left   <= '0;
      run_en     <= 1'b0;
      wr_row     <= '0;
      wr_col     <= '0;
      wr_data    <= '0;
      dump_row   <= '0;
      dump_col   <= '0;
      line_buf   <= '0;
      wait_cnt   <= '0;
      hdr        <= 1'b0;
      step_pulse <= 1'b0;
      wr_pulse   <= 1'b0;
      demo_pulse <= 1'b0;
      rst_pulse  <= 1'b0;
    end else begin
      state      <= state_d;
      tx_data    <= tx_data_d;
      tx_valid   <= tx_valid_d;
      step_count <= step_count_d;
      run_left   <= run_left_d;
      run_en     <= run_en_d;
      wr_row     <= wr_row_d;
      wr_col     <= wr_col_d;
      wr_data    <= wr_data_d;
      dump_row   <= dump_row_d;
      dump_col   <= dump_col_d;
      line_buf   <= line_buf_d;
      wait_cnt   <= wait_cnt_d;
      hdr        <= hdr_d;
      step_pulse <= step_pulse_d;
      wr_pulse   <= wr_pulse_d;
      demo_pulse <= demo_pulse_d;
      rst_pulse  <= rst_pulse_d;
    end
  end

endmodule

// File: tb/tb_silife_uart_cmd.sv
// Directed bench for silife_uart_cmd with a row-k-equals-k grid model.
module tb_silife_uart_cmd;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [4:0] grid_row_sel;
  logic       grid_wr_en;
  logic [7:0] grid_wr_data;
  logic [7:0] grid_rd_data;
  logic       grid_en;
  logic       grid_rst_n;
  logic       max_en;

  silife_uart_cmd dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .grid_row_sel(grid_row_sel), .grid_wr_en(grid_wr_en), .grid_wr_data(grid_wr_data),
    .grid_rd_data(grid_rd_data), .grid_en(grid_en), .grid_rst_n(grid_rst_n), .max_en(max_en)
  );

  always #5 clk = ~clk;

  // grid model: row k holds value k, one cycle read latency
  always @(posedge clk) grid_rd_data <= {3'b000, grid_row_sel};

  int         n_err = 0, n_chk = 0;
  logic [7:0] txb [0:1023];
  int         tx_n = 0, en_cnt = 0, streak = 0, last_streak = 0, rstn_low = 0;
  int         wr_n = 0, stab_err = 0;
  logic [4:0] wr_rows [0:7];
  logic [7:0] wr_dat [0:7];
  logic       hold_q = 1'b0;
  logic [7:0] hold_d = 8'h00;

  always @(posedge clk) begin
    if (!rst) begin
      if (tx_valid && tx_ready) begin
        if (tx_n < 1024) txb[tx_n] <= tx_data;
        tx_n <= tx_n + 1;
      end
      if (grid_en) begin
        en_cnt <= en_cnt + 1;
        streak <= streak + 1;
      end else if (streak != 0) begin
        last_streak <= streak;
        streak <= 0;
      end
      if (!grid_rst_n) rstn_low <= rstn_low + 1;
      if (grid_wr_en && wr_n < 8) begin
        wr_rows[wr_n] <= grid_row_sel;
        wr_dat[wr_n]  <= grid_wr_data;
        wr_n <= wr_n + 1;
      end
      if (hold_q && (!tx_valid || tx_data != hold_d)) stab_err <= stab_err + 1;
      hold_q <= tx_valid && !tx_ready;
      hold_d <= tx_data;
    end else begin
      hold_q <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int k = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && k < 500) begin tick(1); k++; end
    if (!rx_ready) chk("accept_timeout", {31'b0, rx_ready}, 32'd1);
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int target, input int budget, input string tag);
    int k = 0;
    while (tx_n < target && k < budget) begin tick(1); k++; end
    if (tx_n < target) chk({tag, "_timeout"}, tx_n, target);
  endtask

  task automatic cmd(input logic [7:0] b, input logic [7:0] r, input string tag);
    int tn = tx_n;
    send(b);
    wait_tx(tn + 1, 200, tag);
    chk(tag, {24'b0, txb[tn]}, {24'b0, r});
  endtask

  function automatic logic [7:0] exp_dump(input int i);
    int j, row, p;
    if (i == 0) return 8'h0d;
    if (i == 1) return 8'h0a;
    j = i - 2; row = j / 10; p = j % 10;
    if (p < 8) return ((row >> p) & 1) != 0 ? 8'h23 : 8'h2e;
    return (p == 8) ? 8'h0d : 8'h0a;
  endfunction

  task automatic dump_run(input logic [7:0] b, input bit stall, input int nbytes,
                          output int base, output int bad_max, output int bad_en);
    int k = 0;
    base = tx_n; bad_max = 0; bad_en = 0;
    send(b);
    while (tx_n < base + nbytes && k < 20000) begin
      if (max_en) bad_max++;
      if (grid_en) bad_en++;
      if (stall) tx_ready = 1'($urandom_range(0, 1));
      tick(1);
      k++;
    end
    tx_ready = 1'b1;
    chk("dump_count", tx_n - base, nbytes);
  endtask

  task automatic chk_dump(input int base, input string tag);
    int bad = 0;
    for (int i = 0; i < 322; i++)
      if (txb[base + i] !== exp_dump(i)) bad++;
    chk(tag, bad, 0);
  endtask

  initial begin
    int tn, s0, e0, w0, base, bmax, ben;
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1;
    tick(3);
    chk("rst_rx_ready", {31'b0, rx_ready}, 0);
    chk("rst_grid_rst_n", {31'b0, grid_rst_n}, 0);
    chk("rst_tx_valid", {31'b0, tx_valid}, 0);
    chk("rst_tx_data", {24'b0, tx_data}, 0);
    chk("rst_grid_en", {31'b0, grid_en}, 0);
    chk("rst_wr_en", {31'b0, grid_wr_en}, 0);
    chk("rst_row_sel", {27'b0, grid_row_sel}, 0);
    chk("rst_wr_data", {24'b0, grid_wr_data}, 0);
    chk("rst_max_en", {31'b0, max_en}, 1);
    rst = 1'b0;
    tick(1);
    chk("post_rst_rx_ready", {31'b0, rx_ready}, 1);
    chk("post_rst_grid_rst_n", {31'b0, grid_rst_n}, 1);

    // 'z': single response, single-cycle grid reset
    tn = tx_n; s0 = rstn_low;
    send(8'h7a);
    chk("z_tx_valid", {31'b0, tx_valid}, 1);
    chk("z_tx_data", {24'b0, tx_data}, 32'h5a);
    wait_tx(tn + 1, 50, "z_resp");
    tick(5);
    chk("z_byte", {24'b0, txb[tn]}, 32'h5a);
    chk("z_once", tx_n - tn, 1);
    chk("z_rstn_low", rstn_low - s0, 1);
    chk("z_rx_ready", {31'b0, rx_ready}, 1);

    // decimal run of 12 steps, then an empty run
    cmd(8'h31, 8'h31, "echo_1");
    cmd(8'h32, 8'h32, "echo_2");
    e0 = en_cnt;
    cmd(8'h6e, 8'h4e, "run12_resp");
    chk("run12_pulses", en_cnt - e0, 12);
    chk("run12_streak", last_streak, 12);
    e0 = en_cnt;
    cmd(8'h4e, 8'h4e, "run0_resp");
    chk("run0_pulses", en_cnt - e0, 0);

    // two rows: "#......." then "........"
    cmd(8'h77, 8'h57, "w_resp");
    w0 = wr_n;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] c;
      c = (i == 0) ? 8'h23 : 8'h2e;
      cmd(c, c, "cell_echo");
    end
    chk("wr_pulses", wr_n - w0, 2);
    chk("wr0_row", {27'b0, wr_rows[w0]}, 0);
    chk("wr0_data", {24'b0, wr_dat[w0]}, 32'h01);
    chk("wr1_row", {27'b0, wr_rows[w0 + 1]}, 1);
    chk("wr1_data", {24'b0, wr_dat[w0 + 1]}, 32'h00);
    chk("row_sel_after_wr", {27'b0, grid_row_sel}, 2);

    // free-run on, then a full dump: stepping frozen, MAX7219 refresh off
    cmd(8'h70, 8'h50, "p_on");
    chk("free_run_en", {31'b0, grid_en}, 1);
    dump_run(8'h72, 1'b0, 322, base, bmax, ben);
    chk_dump(base, "dump_bytes");
    chk("dump_max_en_low", bmax, 0);
    chk("dump_grid_en_low", ben, 0);
    chk("dump_max_en_after", {31'b0, max_en}, 1);
    tick(5);
    chk("dump_no_extra", tx_n - base, 322);

    // same dump under random back-pressure
    dump_run(8'h72, 1'b1, 322, base, bmax, ben);
    chk_dump(base, "stall_dump_bytes");
    chk("stall_dump_max_en", bmax, 0);

    // free-run off, then a step whose response is stalled
    cmd(8'h50, 8'h50, "p_off");
    e0 = en_cnt; tn = tx_n;
    tx_ready = 1'b0;
    send(8'h53);
    tick(20);
    chk("stall_tx_valid", {31'b0, tx_valid}, 1);
    chk("stall_tx_data", {24'b0, tx_data}, 32'h53);
    chk("stall_rx_ready", {31'b0, rx_ready}, 0);
    chk("stall_no_byte", tx_n - tn, 0);
    tx_ready = 1'b1;
    wait_tx(tn + 1, 50, "s_resp");
    chk("s_byte", {24'b0, txb[tn]}, 32'h53);
    chk("s_pulse", en_cnt - e0, 1);
    chk("stable_while_stalled", stab_err, 0);

    // demo load: reset+write together, row pointer untouched, free-run on
    s0 = rstn_low; w0 = wr_n;
    cmd(8'h64, 8'h44, "d_resp");
    chk("d_rstn_low", rstn_low - s0, 1);
    chk("d_wr_pulse", wr_n - w0, 1);
    chk("d_row_sel", {27'b0, grid_row_sel}, 2);
    chk("d_run_en", {31'b0, grid_en}, 1);

    // reset in the middle of a dump
    dump_run(8'h72, 1'b0, 100, base, bmax, ben);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_tx_valid", {31'b0, tx_valid}, 0);
    chk("mid_rst_max_en", {31'b0, max_en}, 1);
    chk("mid_rst_rx_ready", {31'b0, rx_ready}, 0);
    chk("mid_rst_row_sel", {27'b0, grid_row_sel}, 0);
    chk("mid_rst_grid_en", {31'b0, grid_en}, 0);
    rst = 1'b0;
    tick(1);
    chk("mid_rst_grid_rst_n", {31'b0, grid_rst_n}, 1);
    cmd(8'h71, 8'h58, "q_unknown");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
